pma_region_table: RTL
=====================

# pma_region_table

Runtime-programmable physical-memory-attribute table for CVA6. It generalises the static execute, cached and non-idempotent region lists in the core configuration into `NrRules` CSR-writable rules with per-rule attributes and lock. A two-stage pipelined lookup port returns the attributes for a physical address. It sits between the CSR file (config port) and the fetch/LSU PMA check path (lookup port).

## Interface
Parameters:
- `NrRules`, 8: number of rules, 1..16.
- `AddrWidth`, 64: physical address and rule field width.
- `DefaultAttr`, 3'b000: `{nonidem, cached, exec}` returned on miss.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `cfg_req_i` in 1: config access request, single cycle.
- `cfg_we_i` in 1: 1 = write, 0 = read.
- `cfg_idx_i` in 4: rule index.
- `cfg_sel_i` in 2: field select; 0 = base, 1 = length, 2 = ctrl, 3 = reserved.
- `cfg_wdata_i` in AddrWidth: write data.
- `cfg_rvalid_o` out 1: response valid, one cycle after `cfg_req_i`.
- `cfg_rdata_o` out AddrWidth: read data; 0 for writes and errors.
- `cfg_err_o` out 1: index ≥ NrRules, sel = 3, or write to a locked rule.
- `lu_valid_i` in 1 / `lu_ready_o` out 1: lookup request handshake.
- `lu_addr_i` in AddrWidth: lookup address.
- `lu_valid_o` out 1 / `lu_ready_i` in 1: result handshake.
- `lu_hit_o` out 1: an enabled rule matched.
- `lu_idx_o` out 4: matching rule index; 0 on miss.
- `lu_exec_o`, `lu_cached_o`, `lu_nonidem_o` out 1 each: result attributes.

## Operation
- Ctrl word bits: [0] en, [1] exec, [2] cached, [3] nonidem, [7] lock. Other bits read as 0.
- Rule `i` matches when `en` is set and `(addr - base) < length`.
  - Unsigned AddrWidth subtraction, with the condition `addr >= base` also required.
  - `length == 0` never matches.
  - `base + length` overflowing past 2^AddrWidth is legal; the region ends at the top of the address space.
- Priority: the lowest matching index wins. On a miss, `lu_hit_o = 0`, `lu_idx_o = 0` and the attributes equal `DefaultAttr`.
- Writes update the addressed field at the next clock edge.
- Lock: once `lock` is set, all later writes to that rule (base, length, ctrl) are dropped with `cfg_err_o = 1`. Only reset clears lock.
  - A write that sets lock also applies the other ctrl bits in the same word.
- Reads return the field value. Reads of a locked rule succeed.
- Pipeline:
  - S1 captures the per-rule match vector plus a snapshot of every rule's attributes. These are computed from `lu_addr_i` and the table as it stands before any same-cycle config write.
  - S2 priority-encodes and registers the result.
  - A lookup therefore always reflects the table state on its accept edge, even if a write lands while it is in flight.
- Backpressure:
  - `s2_adv = !s2_valid || lu_ready_i`
  - `lu_ready_o = !s1_valid || s2_adv`
  - No combinational path from `lu_valid_i` to `lu_valid_o`.

## Timing
- Reset values:
  - All rules: base = 0, length = 0, ctrl = 0.
  - S1 and S2 empty; `lu_valid_o = 0` and all lu result outputs = 0.
  - `cfg_rvalid_o`, `cfg_err_o` and `cfg_rdata_o` = 0.
- Config: response registered exactly 1 cycle after `cfg_req_i`. No stall; back-to-back requests are allowed every cycle.
- Lookup: latency 2 cycles with `lu_ready_i` held high; throughput 1 per cycle.
- Stall: S2 holds its outputs stable while `lu_valid_o && !lu_ready_i`. S1 holds too when S2 cannot advance.
- Reset asserted mid-lookup drops in-flight results. Reset asserted mid-config suppresses the pending response.
- Simultaneous accept and write to the same rule: the lookup sees the old value.

## Structure
- Package `pma_region_pkg`:
  - ctrl bit position constants and the `cfg_sel` encoding;
  - `pma_attr_t` struct `{nonidem, cached, exec}`;
  - `pma_rule_t` struct `{base, length, ctrl}`, parameterised through AddrWidth localparams.
- Sub-module `pma_region_match`: single-rule combinational comparator (addr, base, length, en → match), instantiated NrRules times. The top level holds the registers, pipeline and priority encoder.

## Test plan
- Reset, then look up 0x8000_0000 → hit = 0, idx = 0, attr = DefaultAttr, result at cycle 2.
- Program rule 2 as base 0x8000_0000, length 0x4000_0000, ctrl 0x07. Look up 0xBFFF_FFFF → hit, idx 2, exec = 1, cached = 1. Look up 0xC000_0000 → miss.
- Overlap: rule 1 = {0x1_0000, 0x1_0000, exec}, rule 5 = {0x0, 0x10_0000, nonidem}. Look up 0x1_8000 → idx 1. Look up 0x2_0000 → idx 5.
- Lock: write ctrl 0x81 to rule 3, then write base → `cfg_err_o = 1` and read-back unchanged. Index 9 with NrRules = 8 → err.
- Stream 4 lookups with `lu_ready_i` low for 3 cycles → outputs stable, no loss or duplication, results in order. A write to the matched rule during the stall does not change the results.
- Wrap: base 0xFFFF_FFFF_FFFF_F000, length 0x2000. Look up 0xFFFF_FFFF_FFFF_FFF8 → hit. Look up 0x0 → miss.

Source files
------------

// File: rtl/pma_region_pkg.sv
// Shared encodings and types for the PMA region table: ctrl bit layout, field select, attributes.
// Pure declarations; no timing or flow control.
package pma_region_pkg;

   localparam int PMA_ADDR_W = 64;

   localparam int CTRL_EN      = 0;
   localparam int CTRL_EXEC    = 1;
   localparam int CTRL_CACHED  = 2;
   localparam int CTRL_NONIDEM = 3;
   localparam int CTRL_LOCK    = 7;

   // Bits of the ctrl word that are actually stored; the rest read back as zero.
   localparam logic [7:0] CTRL_MASK = 8'h8F;

   typedef enum logic [1:0] {
      SEL_BASE = 2'd0,
      SEL_LEN  = 2'd1,
      SEL_CTRL = 2'd2,
      SEL_RSVD = 2'd3
   } cfg_sel_e;

   typedef struct packed {
      logic nonidem;
      logic cached;
      logic exec;
   } pma_attr_t;

   typedef struct packed {
      logic [PMA_ADDR_W-1:0] base;
      logic [PMA_ADDR_W-1:0] length;
      logic [7:0]            ctrl;
   } pma_rule_t;

endpackage

// File: rtl/pma_region_match.sv
// Single-rule region comparator: hit when enabled and addr lies in [base, base+length), clipped at 2^AW.
// Purely combinational; no flow control.
module pma_region_match #(
   parameter int AddrWidth = 64
) (
   input  logic [AddrWidth-1:0] i_addr,
   input  logic [AddrWidth-1:0] i_base,
   input  logic [AddrWidth-1:0] i_length,
   input  logic                 i_en,
   output logic                 o_match
);

   logic [AddrWidth-1:0] w_offset;

   // Offset form avoids computing base+length, so regions running past the top need no carry.
   assign w_offset = i_addr - i_base;
   assign o_match  = i_en && (i_addr >= i_base) && (w_offset < i_length);

endmodule

// File: rtl/pma_region_table.sv
// CSR-programmable PMA rule table; config answers one cycle after request, lookup returns in 2 cycles.
// Lookup S2 holds while the consumer stalls and S1 holds behind it; config never stalls.
module pma_region_table
   import pma_region_pkg::*;
#(
   parameter int         NrRules     = 8,
   parameter int         AddrWidth   = 64,
   parameter logic [2:0] DefaultAttr = 3'b000
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cfg_req_i,
   input  logic                 cfg_we_i,
   input  logic [3:0]           cfg_idx_i,
   input  logic [1:0]           cfg_sel_i,
   input  logic [AddrWidth-1:0] cfg_wdata_i,
   output logic                 cfg_rvalid_o,
   output logic [AddrWidth-1:0] cfg_rdata_o,
   output logic                 cfg_err_o,
   input  logic                 lu_valid_i,
   output logic                 lu_ready_o,
   input  logic [AddrWidth-1:0] lu_addr_i,
   output logic                 lu_valid_o,
   input  logic                 lu_ready_i,
   output logic                 lu_hit_o,
   output logic [3:0]           lu_idx_o,
   output logic                 lu_exec_o,
   output logic                 lu_cached_o,
   output logic                 lu_nonidem_o
);

   logic [AddrWidth-1:0] r_base [NrRules];
   logic [AddrWidth-1:0] r_len  [NrRules];
   logic [7:0]           r_ctrl [NrRules];

   logic                 r_cfg_rvalid;
   logic                 r_cfg_err;
   logic [AddrWidth-1:0] r_cfg_rdata;

   logic                 w_idx_ok;
   logic                 w_locked;
   logic                 w_err;
   logic                 w_wr;
   logic [AddrWidth-1:0] w_field;

   always_comb begin
      w_idx_ok = ({1'b0, cfg_idx_i} < 5'(NrRules));
      w_locked = 1'b0;
      w_field  = '0;
      for (int i = 0; i < NrRules; i++) begin
         if (cfg_idx_i == 4'(i)) begin
            w_locked = r_ctrl[i][CTRL_LOCK];
            case (cfg_sel_i)
               SEL_BASE: w_field = r_base[i];
               SEL_LEN:  w_field = r_len[i];
               SEL_CTRL: w_field = AddrWidth'(r_ctrl[i]);
               default:  w_field = '0;
            endcase
         end
      end
      w_err = !w_idx_ok || (cfg_sel_i == SEL_RSVD) || (cfg_we_i && w_locked);
      w_wr  = cfg_req_i && cfg_we_i && !w_err;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NrRules; i++) begin
            r_base[i] <= '0;
            r_len[i]  <= '0;
            r_ctrl[i] <= '0;
         end
      end else if (w_wr) begin
         for (int i = 0; i < NrRules; i++) begin
            if (cfg_idx_i == 4'(i)) begin
               case (cfg_sel_i)
                  SEL_BASE: r_base[i] <= cfg_wdata_i;
                  SEL_LEN:  r_len[i]  <= cfg_wdata_i;
                  SEL_CTRL: r_ctrl[i] <= cfg_wdata_i[7:0] & CTRL_MASK;
                  default:  ;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cfg_rvalid <= 1'b0;
         r_cfg_err    <= 1'b0;
         r_cfg_rdata  <= '0;
      end else begin
         r_cfg_rvalid <= cfg_req_i;
         r_cfg_err    <= cfg_req_i && w_err;
         r_cfg_rdata  <= (cfg_req_i && !cfg_we_i && !w_err) ? w_field : '0;
      end
   end

   assign cfg_rvalid_o = r_cfg_rvalid;
   assign cfg_err_o    = r_cfg_err;
   assign cfg_rdata_o  = r_cfg_rdata;

   logic [NrRules-1:0] w_match;
   pma_attr_t          w_attr [NrRules];

   for (genvar g = 0; g < NrRules; g++) begin : g_rule
      pma_region_match #(.AddrWidth(AddrWidth)) u_match (
         .i_addr   (lu_addr_i),
         .i_base   (r_base[g]),
         .i_length (r_len[g]),
         .i_en     (r_ctrl[g][CTRL_EN]),
         .o_match  (w_match[g])
      );
      assign w_attr[g] = '{nonidem: r_ctrl[g][CTRL_NONIDEM],
                           cached:  r_ctrl[g][CTRL_CACHED],
                           exec:    r_ctrl[g][CTRL_EXEC]};
   end

   logic               r_s1_valid;
   logic [NrRules-1:0] r_s1_match;
   pma_attr_t          r_s1_attr [NrRules];
   logic               r_s2_valid;
   logic               r_s2_hit;
   logic [3:0]         r_s2_idx;
   pma_attr_t          r_s2_attr;

   logic      w_s2_adv;
   logic      w_lu_ready;
   logic      w_hit;
   logic [3:0] w_idx;
   pma_attr_t w_res_attr;

   assign w_s2_adv   = !r_s2_valid || lu_ready_i;
   assign w_lu_ready = !r_s1_valid || w_s2_adv;

   // Descending scan so the lowest matching index is the last assignment and wins.
   always_comb begin
      w_hit      = 1'b0;
      w_idx      = '0;
      w_res_attr = pma_attr_t'(DefaultAttr);
      for (int i = NrRules - 1; i >= 0; i--) begin
         if (r_s1_match[i]) begin
            w_hit      = 1'b1;
            w_idx      = 4'(i);
            w_res_attr = r_s1_attr[i];
         end
      end
   end

   // S1 snapshots attributes too, so an in-flight lookup is immune to later writes.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_s1_valid <= 1'b0;
         r_s1_match <= '0;
         for (int i = 0; i < NrRules; i++) r_s1_attr[i] <= '0;
         r_s2_valid <= 1'b0;
         r_s2_hit   <= 1'b0;
         r_s2_idx   <= '0;
         r_s2_attr  <= '0;
      end else begin
         if (w_lu_ready) begin
            r_s1_valid <= lu_valid_i;
            if (lu_valid_i) begin
               r_s1_match <= w_match;
               for (int i = 0; i < NrRules; i++) r_s1_attr[i] <= w_attr[i];
            end
         end
         if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_s2_hit  <= w_hit;
               r_s2_idx  <= w_idx;
               r_s2_attr <= w_res_attr;
            end
         end
      end
   end

   assign lu_ready_o   = w_lu_ready;
   assign lu_valid_o   = r_s2_valid;
   assign lu_hit_o     = r_s2_hit;
   assign lu_idx_o     = r_s2_idx;
   assign lu_exec_o    = r_s2_attr.exec;
   assign lu_cached_o  = r_s2_attr.cached;
   assign lu_nonidem_o = r_s2_attr.nonidem;

endmodule
